seq_mul: RTL and testbench
==========================

# seq_mul

Parametrised sequential shift-add multiplier. It is the area-reduced successor to the single-cycle registered 8-bit multiplier. It trades latency for gate count by reusing a single WIDTH×2 adder across iterations. It produces the full 2·WIDTH-bit unsigned product and connects to datapath neighbours through valid/ready handshakes on both input and output.

## Interface
- `WIDTH`, default 8: operand width in bits; legal values ≥ 2.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operands `a`, `b` are valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  WIDTH: multiplicand, unsigned.
- `b`  in  WIDTH: multiplier, unsigned.
- `out_valid`  out  1: `p` holds a finished product.
- `out_ready`  in  1: consumer accepts `p`.
- `p`  out  2·WIDTH: product register.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- Three-state FSM: IDLE, RUN, DONE.
- Internal registers:
  - `mcand`: 2·WIDTH bits, `a` zero-extended.
  - `mplier`: WIDTH bits.
  - `acc`: 2·WIDTH bits, drives `p`.
  - `cnt`: $clog2(WIDTH) bits.
- IDLE:
  - `in_ready = !rst`.
  - On accept (`in_valid && in_ready`): `mcand←{0,a}`, `mplier←b`, `acc←0`, `cnt←0`, go to RUN.
- RUN, one iteration per cycle:
  - If `mplier[0]`, then `acc←acc+mcand`; the sum is truncated to 2·WIDTH bits and cannot overflow.
  - `mcand←mcand<<1`, `mplier←mplier>>1`, `cnt←cnt+1`.
  - Go to DONE at the end of the iteration where `cnt==WIDTH-1`, or where the early-exit condition holds (see Configuration).
- DONE:
  - `out_valid=1`; `acc`/`p` are frozen.
  - On `out_ready`, go to IDLE.
- `in_ready=0` in RUN and DONE. `in_valid` is ignored there; operands presented then are not latched.
- `p` equals `acc` at all times. It shows partial sums during RUN and is meaningful only while `out_valid=1`. After the output handshake, `p` keeps the last product until the next accept clears it.
- Reset values: state IDLE, `acc`/`p`=0, `mcand`=0, `mplier`=0, `cnt`=0, `out_valid`=0, `busy`=0, `in_ready`=0 while `rst` is high.
- Reset asserted in RUN or DONE: the operation is abandoned with no output. The next cycle after `rst` deasserts has `in_ready=1`.
- `rst` and `in_valid` high in the same cycle: no accept.

## Timing
- Accept in cycle t → RUN occupies cycles t+1 … t+WIDTH → `out_valid` first high in cycle t+WIDTH+1 (early exit disabled).
- `out_valid` stays high until the cycle in which `out_ready` is sampled high. The block is in IDLE in the following cycle, and the earliest next accept is that cycle.
- Peak throughput is one product per WIDTH+2 cycles.
- `out_ready` held high continuously gives exactly one cycle of `out_valid` per product.
- Combinational paths:
  - `in_ready`, `out_valid`, `busy` are decoded from state, plus `rst` for `in_ready`.
  - There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `SEQ_MUL_EARLY_EXIT_EN` defined: RUN also exits to DONE at the end of any iteration whose shifted `mplier` (after `>>1`) is zero.
  - Latency becomes max(1, index of the highest set bit of `b` + 1) RUN cycles.
  - `b=0` or `b=1` → `out_valid` at t+2.
- Undefined: RUN always takes exactly WIDTH cycles, with data-independent latency.
- The product value is identical in both builds.

## Test plan
- WIDTH=8, `a=13`, `b=11`, `out_ready=1`:
  - `p=143`.
  - `out_valid` at t+9 without the macro.
  - `out_valid` at t+5 with `SEQ_MUL_EARLY_EXIT_EN`.
- WIDTH=8, `a=255`, `b=255`: `p=16'hFE01` at t+9 in both builds. Then `a=0`, `b=200` accepted the cycle after the output handshake: `p=0`.
- Backpressure: hold `out_ready=0` for 5 cycles after `out_valid` rises. Required: `p` and `out_valid` stay stable, `in_ready=0`, and a new `in_valid` pulse in that window is not accepted.
- Reset mid-RUN: assert `rst` at cycle t+3 of a 200×3 multiply. Required: the next cycle has `busy=0`, `out_valid=0`, `p=0`, with no stray `out_valid` afterwards.
- WIDTH=16, `a=16'hFFFF`, `b=16'h8001`: `p=32'h8000_7FFF` at t+17 in both builds, since the top bit is set.
- Random sweep: 1000 operand pairs at WIDTH=8 and WIDTH=5 with random `in_valid`/`out_ready` gaps. Every product must match `a*b`, with no lost or duplicated transactions.

Source files
------------

// File: rtl/seq_mul.sv
// seq_mul: sequential shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One adder is reused across WIDTH iterations; valid/ready handshakes on both
// the operand side and the product side.
//
// Optional build macro: SEQ_MUL_EARLY_EXIT_EN
//   defined   -> RUN also ends once the remaining multiplier bits are all zero
//   undefined -> RUN always takes exactly WIDTH cycles (data-independent latency)
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready high (unless rst)
// S_RUN  | one shift-add iteration per cycle
// S_DONE | product valid on p, held until out_ready
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mplier_shr;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_iter;

  assign mplier_shr = mplier >> 1;
  assign p          = acc;

  // Decide whether the current RUN iteration is the final one.
  always_comb begin
    last_iter = (cnt == CNT_LAST);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    // Remaining multiplier bits all zero: further iterations add nothing.
    if (mplier_shr == '0) last_iter = 1'b1;
`endif
  end

  // Next-state and handshake decode; outputs depend only on state (and rst).
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath: load operands on accept, shift-add while running, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_RUN) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier_shr;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: three instances (WIDTH 8, 5, 16), a directed
// vector table, hand-written backpressure/reset sequences and a random sweep
// scored against plain a*b and a latency model.
module tb_seq_mul;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        iv[3];
  logic        ordy[3];
  logic [15:0] ai[3];
  logic [15:0] bi[3];
  logic        ir[3];
  logic        ov[3];
  logic        bz[3];
  logic [31:0] po[3];

  logic [7:0]  a0, b0;
  logic [15:0] p0;
  logic [4:0]  a1, b1;
  logic [9:0]  p1;
  logic [15:0] a2, b2;
  logic [31:0] p2;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;

  assign a0 = ai[0][7:0];
  assign b0 = bi[0][7:0];
  assign a1 = ai[1][4:0];
  assign b1 = bi[1][4:0];
  assign a2 = ai[2];
  assign b2 = bi[2];

  always_comb begin
    po[0] = 32'(p0);
    po[1] = 32'(p1);
    po[2] = p2;
    ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
    ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
    bz[0] = bz0; bz[1] = bz1; bz[2] = bz2;
  end

  seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .a(a0), .b(b0),
    .out_valid(ov0), .out_ready(ordy[0]), .p(p0), .busy(bz0));

  seq_mul #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(ordy[1]), .p(p1), .busy(bz1));

  seq_mul #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(ordy[2]), .p(p2), .busy(bz2));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  typedef struct {
    logic [31:0] p;
    logic [15:0] b;
    int          acc_cyc;
  } txn_t;

  txn_t sq[2][$];

  function automatic int wd(input int u);
    return (u == 0) ? 8 : (u == 1) ? 5 : 16;
  endfunction

  function automatic logic [15:0] msk(input int u);
    return 16'((32'd1 << wd(u)) - 32'd1);
  endfunction

  // RUN cycles for a multiplier value: full width, or up to its top set bit.
  function automatic int lat_of(input int w, input logic [15:0] b);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    int hi;
    hi = 0;
    for (int i = 0; i < w; i++) if (b[i]) hi = i;
    return hi + 1;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One transaction with out_ready held high; starts and ends at a negedge.
  task automatic run_one(input int u, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p);
    int n;
    ordy[u] = 1'b1;
    ai[u] = a;
    bi[u] = b;
    iv[u] = 1'b1;
    n = 0;
    while (!ir[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    iv[u] = 1'b0;
    n = 1;
    while (!ov[u] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat_of(wd(u), b) + 1));
    chk("product", po[u], exp_p);
    chk("model_product", po[u], 32'(a) * 32'(b));
    chk("in_ready_in_done", 32'(ir[u]), 32'd0);
    @(negedge clk);
    chk("out_valid_one_cycle", 32'(ov[u]), 32'd0);
    chk("in_ready_after_hs", 32'(ir[u]), 32'd1);
    chk("busy_after_hs", 32'(bz[u]), 32'd0);
  endtask

  task automatic drive(input int u, input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      iv[u] = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ai[u] = 16'($urandom) & msk(u);
      bi[u] = 16'($urandom) & msk(u);
      iv[u] = 1'b1;
      k = 0;
      while (!ir[u] && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (k >= 200) chk("rand_accept_timeout", 32'd1, 32'd0);
      sq[u].push_back('{p: 32'(ai[u]) * 32'(bi[u]), b: bi[u], acc_cyc: cyc});
      @(negedge clk);
    end
    iv[u] = 1'b0;
  endtask

  task automatic mon(input int u, input int n);
    int   got;
    int   budget;
    logic first;
    txn_t t;
    got = 0;
    budget = 0;
    first = 1'b1;
    while (got < n && budget < 40000) begin
      @(negedge clk);
      budget++;
      ordy[u] = ($urandom_range(0, 3) != 0);
      if (ov[u]) begin
        if (sq[u].size() == 0) begin
          chk("rand_spurious_out_valid", 32'd1, 32'd0);
        end else begin
          t = sq[u][0];
          if (first) chk("rand_latency", 32'(cyc - t.acc_cyc), 32'(lat_of(wd(u), t.b) + 1));
          first = 1'b0;
          chk("rand_product", po[u], t.p);
          if (ordy[u]) begin
            void'(sq[u].pop_front());
            got++;
            first = 1'b1;
          end
        end
      end
    end
    if (got < n) chk("rand_done_timeout", 32'(got), 32'(n));
    ordy[u] = 1'b1;
  endtask

  vec_t tv[8];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic stray;

    tv[0] = '{a: 16'd13,  b: 16'd11,  p: 32'd143};
    tv[1] = '{a: 16'd255, b: 16'd255, p: 32'hFE01};
    tv[2] = '{a: 16'd0,   b: 16'd200, p: 32'd0};
    tv[3] = '{a: 16'd1,   b: 16'd1,   p: 32'd1};
    tv[4] = '{a: 16'd0,   b: 16'd0,   p: 32'd0};
    tv[5] = '{a: 16'd128, b: 16'd128, p: 32'd16384};
    tv[6] = '{a: 16'd200, b: 16'd3,   p: 32'd600};
    tv[7] = '{a: 16'd2,   b: 16'd64,  p: 32'd128};

    for (int u = 0; u < 3; u++) begin
      iv[u] = 1'b0;
      ordy[u] = 1'b1;
      ai[u] = '0;
      bi[u] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(ir[0]), 32'd0);
    chk("reset_out_valid", 32'(ov[0]), 32'd0);
    chk("reset_busy", 32'(bz[0]), 32'd0);
    chk("reset_p", po[0], 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 32'(ir[0]), 32'd1);
    @(negedge clk);

    // Directed table, back-to-back (each accept is the cycle after the prior handshake).
    for (int i = 0; i < 8; i++) run_one(0, tv[i].a, tv[i].b, tv[i].p);

    // Wide operands: top bit of b set, so latency is full width in either build.
    run_one(2, 16'hFFFF, 16'h8001, 32'h8000_7FFF);

    // Backpressure: product held, in_ready low, stray in_valid ignored.
    ordy[0] = 1'b0;
    ai[0] = 16'd9;
    bi[0] = 16'd7;
    iv[0] = 1'b1;
    n = 0;
    while (!ir[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("bp_out_valid_timeout", 32'd1, 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk("bp_out_valid_held", 32'(ov[0]), 32'd1);
      chk("bp_p_held", po[0], 32'd63);
      chk("bp_in_ready_low", 32'(ir[0]), 32'd0);
      if (k == 1) begin
        iv[0] = 1'b1;
        ai[0] = 16'd3;
        bi[0] = 16'd3;
      end
      if (k == 2) iv[0] = 1'b0;
      if (k == 5) ordy[0] = 1'b1;
      @(negedge clk);
    end
    chk("bp_released", 32'(ov[0]), 32'd0);
    chk("bp_p_kept_after_hs", po[0], 32'd63);
    stray = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ov[0] || bz[0]) stray = 1'b1;
    end
    chk("bp_pulse_not_accepted", 32'(stray), 32'd0);

    // Reset during RUN, then rst together with in_valid.
    ai[0] = 16'd200;
    bi[0] = 16'd3;
    iv[0] = 1'b1;
    n = 0;
    while (!ir[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_run_busy", 32'(bz[0]), 32'd0);
    chk("rst_run_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_run_p", po[0], 32'd0);
    chk("rst_in_ready_low", 32'(ir[0]), 32'd0);
    iv[0] = 1'b1;
    ai[0] = 16'd5;
    bi[0] = 16'd5;
    @(negedge clk);
    chk("rst_with_in_valid_no_accept", 32'(bz[0]), 32'd0);
    rst = 1'b0;
    iv[0] = 1'b0;
    #1;
    chk("in_ready_after_rst_release", 32'(ir[0]), 32'd1);
    stray = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ov[0] || bz[0]) stray = 1'b1;
    end
    chk("rst_no_stray_output", 32'(stray), 32'd0);

    // Random sweep at WIDTH 8 and 5 concurrently.
    fork
      drive(0, 1000);
      mon(0, 1000);
      drive(1, 1000);
      mon(1, 1000);
    join
    chk("rand_queue_empty_w8", 32'(sq[0].size()), 32'd0);
    chk("rand_queue_empty_w5", 32'(sq[1].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
